oled_draw_arbiter: RTL and testbench



---
 rtl/oled_pkg.sv | 16 +
 rtl/oled_draw_arbiter_rr_pick.sv | 35 +++
 rtl/oled_draw_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_oled_draw_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and field widths for the OLED character-draw arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } oled_state_t;

  localparam int OLED_PLACE_W = 2;
  localparam int OLED_CHAR_W  = 5;

endpackage

// File: rtl/oled_draw_arbiter_rr_pick.sv
// Round-robin one-hot picker: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; gnt is all-zero when no request is set.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt
);

  localparam int IW = $clog2(NREQ);

  int          pos;
  logic [IW-1:0] sel;
  logic        found;

  // Scan requesters starting at ptr, first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      sel = IW'(pos);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_draw_arbiter.sv
// Arbitrates character-draw requests onto one OLED driver; macro OLED_ARB_TIMEOUT_EN adds an ISSUE timeout.
// Latency: req in an idle system -> drv_draw high two cycles later; done one cycle after driver goes idle.
// Backpressure: drv_busy high in IDLE blocks grants; ISSUE holds drv_draw until the driver reports busy.
module oled_draw_arbiter
  import oled_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               req_mode,
  input  logic [OLED_PLACE_W*NREQ-1:0]  req_place,
  input  logic [OLED_CHAR_W*NREQ-1:0]   req_char,
  output logic [NREQ-1:0]               done,
  output logic                          drv_mode,
  output logic [OLED_PLACE_W-1:0]       drv_place,
  output logic [OLED_CHAR_W-1:0]        drv_char,
  output logic                          drv_draw,
  input  logic                          drv_busy,
  input  logic                          drv_ack_err,
  output logic [$clog2(NREQ)-1:0]       grant_id,
  output logic                          err_ack,
  output logic                          err_tmo
);

  localparam int IW = $clog2(NREQ);

  oled_state_t             state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic                    mode_q, mode_d;
  logic [OLED_PLACE_W-1:0] place_q, place_d;
  logic [OLED_CHAR_W-1:0]  char_q, char_d;
  logic                    drv_draw_q, drv_draw_d;
  logic [NREQ-1:0]         done_q, done_d;
  logic                    err_ack_q, err_ack_d;

  logic [NREQ-1:0]         gnt_oh;
  logic [IW-1:0]           pick_idx;
  logic                    pick_mode;
  logic [OLED_PLACE_W-1:0] pick_place;
  logic [OLED_CHAR_W-1:0]  pick_char;

`ifdef OLED_ARB_TIMEOUT_EN
  localparam int            TMO_W    = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                     err_tmo_q, err_tmo_d;
`endif

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt_oh)
  );

  // Convert the one-hot winner into an index and mux out its glyph fields.
  always_comb begin
    pick_idx   = '0;
    pick_mode  = 1'b0;
    pick_place = '0;
    pick_char  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        pick_idx   = IW'(i);
        pick_mode  = req_mode[i];
        pick_place = req_place[i*OLED_PLACE_W +: OLED_PLACE_W];
        pick_char  = req_char[i*OLED_CHAR_W +: OLED_CHAR_W];
      end
    end
  end

  // Next-state and next-output logic for the grant/issue/run/done sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    mode_d     = mode_q;
    place_d    = place_q;
    char_d     = char_q;
    drv_draw_d = 1'b0;
    done_d     = '0;
    err_ack_d  = err_ack_q | drv_ack_err;
`ifdef OLED_ARB_TIMEOUT_EN
    tmo_cnt_d  = '0;
    err_tmo_d  = err_tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!drv_busy && (|req)) begin
          grant_d = pick_idx;
          mode_d  = pick_mode;
          place_d = pick_place;
          char_d  = pick_char;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        drv_draw_d = 1'b1;
        if (drv_busy) begin
          drv_draw_d = 1'b0;
          state_d    = ST_RUN;
        end
`ifdef OLED_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          // Driver never acknowledged the strobe: give up and release the requester.
          drv_draw_d      = 1'b0;
          err_tmo_d       = 1'b1;
          done_d[grant_q] = 1'b1;
          state_d         = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_RUN: begin
        if (!drv_busy) begin
          done_d[grant_q] = 1'b1;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state and registered driver-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      mode_q     <= 1'b0;
      place_q    <= '0;
      char_q     <= '0;
      drv_draw_q <= 1'b0;
      done_q     <= '0;
      err_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      mode_q     <= mode_d;
      place_q    <= place_d;
      char_q     <= char_d;
      drv_draw_q <= drv_draw_d;
      done_q     <= done_d;
      err_ack_q  <= err_ack_d;
    end
  end

`ifdef OLED_ARB_TIMEOUT_EN
  // ISSUE-phase timeout counter and its sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign err_tmo = err_tmo_q;
`else
  assign err_tmo = 1'b0;
`endif

  assign done      = done_q;
  assign drv_mode  = mode_q;
  assign drv_place = place_q;
  assign drv_char  = char_q;
  assign drv_draw  = drv_draw_q;
  assign grant_id  = grant_q;
  assign err_ack   = err_ack_q;

endmodule

// File: tb/tb_oled_draw_arbiter.sv
// Directed bench for oled_draw_arbiter with a small behavioural OLED driver model.
// Latency: n/a.
// Backpressure: driver busy comes from the model or a forced hold.
module tb_oled_draw_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_mode, done;
  logic [7:0]  req_place;
  logic [19:0] req_char;
  logic        drv_mode, drv_draw, drv_busy, drv_ack_err, err_ack, err_tmo;
  logic [1:0]  drv_place, grant_id;
  logic [4:0]  drv_char;

  logic        model_busy = 1'b0;
  logic        hold_busy;
  logic        model_en;
  int          rise_dly, hold_dly;

  int          n_vec, n_err;
  int          cnt, cyc;
  logic [3:0]  d;
  int          order_a [5] = '{0, 1, 2, 3, 0};
  int          order_b [4] = '{0, 3, 0, 3};

  assign drv_busy = model_busy | hold_busy;

  always #5 clk = ~clk;

  oled_draw_arbiter #(.NREQ(4), .TMO_CYC(50)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_mode    (req_mode),
    .req_place   (req_place),
    .req_char    (req_char),
    .done        (done),
    .drv_mode    (drv_mode),
    .drv_place   (drv_place),
    .drv_char    (drv_char),
    .drv_draw    (drv_draw),
    .drv_busy    (drv_busy),
    .drv_ack_err (drv_ack_err),
    .grant_id    (grant_id),
    .err_ack     (err_ack),
    .err_tmo     (err_tmo)
  );

  // Driver model: busy rises rise_dly edges after draw is seen, stays for hold_dly edges.
  always begin
    @(negedge clk);
    if (drv_draw && model_en) begin
      repeat (rise_dly) @(posedge clk);
      #1 model_busy = 1'b1;
      repeat (hold_dly) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    drv_ack_err = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_glyph(input int i, input logic m, input logic [1:0] p, input logic [4:0] c);
    req_mode[i]       = m;
    req_place[2*i +: 2] = p;
    req_char[5*i +: 5]  = c;
  endtask

  task automatic wait_done(input int limit, output logic [3:0] dd, output int cc);
    dd = '0;
    cc = 0;
    while (cc < limit && dd == 4'b0) begin
      tick();
      cc++;
      dd = done;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; req = '0; req_mode = '0; req_place = '0; req_char = '0;
    drv_ack_err = 1'b0; hold_busy = 1'b0; model_en = 1'b1;
    rise_dly = 3; hold_dly = 200;
    repeat (3) tick();

    // Reset values
    check("rst_draw",  drv_draw,  0);
    check("rst_done",  done,      0);
    check("rst_grant", grant_id,  0);
    check("rst_place", drv_place, 0);
    check("rst_char",  drv_char,  0);
    check("rst_mode",  drv_mode,  0);
    check("rst_eack",  err_ack,   0);
    check("rst_etmo",  err_tmo,   0);
    rst = 1'b0;
    tick();

    // No requests: stays idle
    cnt = 0;
    repeat (20) begin tick(); if (drv_draw) cnt++; end
    check("idle_nodraw", cnt, 0);

    // Single requester 1, place 2, char 7, busy 3 after draw for 200
    set_glyph(1, 1'b1, 2'd2, 5'd7);
    req = 4'b0010;
    tick();
    check("lat1_draw",  drv_draw,  0);
    check("lat1_grant", grant_id,  1);
    check("lat1_place", drv_place, 2);
    check("lat1_char",  drv_char,  7);
    check("lat1_mode",  drv_mode,  1);
    tick();
    check("lat2_draw", drv_draw, 1);
    cnt = 1;
    while (drv_draw && cnt < 50) begin tick(); if (drv_draw) cnt++; end
    check("draw_len", cnt, 4);
    req_char[9:5]  = 5'd31;
    req_place[3:2] = 2'd0;
    wait_done(400, d, cyc);
    check("done1_oh",   d,         4'b0010);
    check("done1_cyc",  cyc,       200);
    check("hold_char",  drv_char,  7);
    check("hold_place", drv_place, 2);
    req = '0;
    tick();
    check("done1_pulse", done, 0);

    // All four held: round-robin 0,1,2,3,0
    do_reset();
    rise_dly = 1; hold_dly = 5;
    for (int i = 0; i < 4; i++) set_glyph(i, 1'b0, 2'(i), 5'(10 + i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(100, d, cyc);
      check("rr4_done",  d,        4'b0001 << order_a[k]);
      check("rr4_grant", grant_id, order_a[k]);
      check("rr4_char",  drv_char, 10 + order_a[k]);
      if (k == 4) req = '0;
      tick();
      check("rr4_pulse", done, 0);
    end

    // Requesters 0 and 3 held: alternate 0,3,0,3
    do_reset();
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_done(100, d, cyc);
      check("alt_done", d, 4'b0001 << order_b[k]);
    end
    req = '0;
    tick();

    // Driver busy from reset blocks grants
    hold_busy = 1'b1;
    do_reset();
    set_glyph(2, 1'b0, 2'd3, 5'd21);
    req = 4'b0100;
    cnt = 0;
    repeat (500) begin tick(); if (drv_draw) cnt++; end
    check("blk_nodraw", cnt, 0);
    check("blk_grant",  grant_id, 0);
    hold_busy = 1'b0;
    wait_done(100, d, cyc);
    check("blk_done",  d,         4'b0100);
    check("blk_char",  drv_char,  21);
    check("blk_place", drv_place, 3);
    req = '0;
    tick();

`ifdef OLED_ARB_TIMEOUT_EN
    // Driver never responds: timeout after 50 ISSUE cycles
    do_reset();
    model_en = 1'b0;
    req = 4'b0001;
    tick();
    cyc = 0;
    while (!err_tmo && cyc < 100) begin tick(); cyc++; end
    check("tmo_cyc",  cyc,      50);
    check("tmo_done", done,     4'b0001);
    check("tmo_draw", drv_draw, 0);
    req = '0;
    tick();
    check("tmo_pulse", done, 0);
    model_en = 1'b1;
`endif

    // Ack error is sticky; reset during RUN clears everything with no done
    do_reset();
    hold_dly = 200;
    set_glyph(1, 1'b1, 2'd2, 5'd9);
    req = 4'b0010;
    cyc = 0;
    while (!model_busy && cyc < 50) begin tick(); cyc++; end
    tick();
    drv_ack_err = 1'b1;
    tick();
    drv_ack_err = 1'b0;
    check("ack_set", err_ack, 1);
    tick();
    check("ack_hold",  err_ack,  1);
    check("run_grant", grant_id, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_draw",  drv_draw,  0);
    check("arst_grant", grant_id,  0);
    check("arst_char",  drv_char,  0);
    check("arst_place", drv_place, 0);
    check("arst_mode",  drv_mode,  0);
    check("arst_eack",  err_ack,   0);
    check("arst_done",  done,      0);
    req = '0;
    repeat (2) tick();
    rst = 1'b0;
    cnt = 0;
    repeat (250) begin tick(); if (done != 4'b0) cnt++; end
    check("arst_nodone", cnt, 0);
    check("end_etmo", err_tmo, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
